// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm sequencer.
// Contents:
//   DEF_*          default parameter values for the sequencer and its bus
//   state_t        playback FSM states
//   step_entry_t   one pattern entry {div, len, rest} at the default widths
package rhythm_pkg;

    localparam int DEF_STEPS    = 8;
    localparam int DEF_DIV_W    = 16;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_TICK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_DIV_W-1:0] div;   // tone half-period in clk cycles, 0 = silent
        logic [DEF_LEN_W-1:0] len;   // step length in beats, 0 = skip
        logic                 rest;  // step is silent
    } step_entry_t;

endpackage

// File: rtl/rhythm_seq_if.sv
// Control/status bundle of the rhythm sequencer.
// Signals:
//   cfg_we, cfg_addr, cfg_div, cfg_len, cfg_rest  pattern write port
//   start, stop, loop                             playback control
//   busy, step_idx, step_strobe, tone_out, done   playback status
// Modports:
//   master  drives configuration/control, observes status
//   slave   the sequencer side
interface rhythm_seq_if import rhythm_pkg::*; #(
    parameter int STEPS = DEF_STEPS,
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
);
    localparam int AW = $clog2(STEPS);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [DIV_W-1:0] cfg_div;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_rest;
    logic             start;
    logic             stop;
    logic             loop;
    logic             busy;
    logic [AW-1:0]    step_idx;
    logic             step_strobe;
    logic             tone_out;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_div, cfg_len, cfg_rest, start, stop, loop,
        input  busy, step_idx, step_strobe, tone_out, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_div, cfg_len, cfg_rest, start, stop, loop,
        output busy, step_idx, step_strobe, tone_out, done
    );

endinterface

// File: rtl/rhythm_seq_tone_div.sv
// Square-wave tone divider: toggles tone every div enabled cycles,
// giving a period of 2*div cycles that starts low after clr.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   clr    restart the waveform (counter and tone to 0)
//   en     advance the counter this cycle
//   div    half-period in clk cycles; 0 holds the output low
//   tone   square-wave output
module tone_div import rhythm_pkg::*; #(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tone
);

    logic [DIV_W-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (en && div != '0) begin
            if (cnt == div - 1'b1) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rhythm_seq.sv
// Rhythm sequencer: plays a STEPS-entry pattern of {div, len, rest} steps,
// each lasting len beats of TICK_DIV clk cycles, emitting a gated square wave.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (also clears the pattern memory)
//   bus    rhythm_seq_if.slave: pattern write port, start/stop/loop control,
//          busy/step_idx/step_strobe/tone_out/done status
module rhythm_seq import rhythm_pkg::*; #(
    parameter int STEPS    = DEF_STEPS,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic         clk,
    input  logic         reset,
    rhythm_seq_if.slave  bus
);

    localparam int AW     = $clog2(STEPS);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [AW-1:0]     LAST_STEP = AW'(STEPS - 1);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [LEN_W-1:0] len;
        logic             rest;
    } entry_t;

    entry_t           mem [STEPS];
    entry_t           mem_rd;
    entry_t           cur;          // entry latched for the step in progress
    state_t           state, state_d;
    logic [AW-1:0]    step_idx, step_d;
    logic [TICK_W-1:0] tick_cnt, tick_d;
    logic [LEN_W-1:0] beat_cnt, beat_d;
    logic             played, played_d;   // a len!=0 step ran in this pass
    logic             load_cur;
    logic             advance;
    logic             tone_raw;

    assign mem_rd = mem[step_idx];

    // NOTE: the pattern memory is cleared on reset, so it is built from flops
    // rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            mem[bus.cfg_addr] <= '{div: bus.cfg_div, len: bus.cfg_len, rest: bus.cfg_rest};
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state;
        step_d   = step_idx;
        tick_d   = tick_cnt;
        beat_d   = beat_cnt;
        played_d = played;
        load_cur = 1'b0;
        advance  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = ST_LOAD;
                    step_d   = '0;
                    played_d = 1'b0;
                end
            end
            ST_LOAD: begin
                load_cur = 1'b1;
                tick_d   = '0;
                beat_d   = '0;
                if (mem_rd.len != '0) begin
                    state_d  = ST_PLAY;
                    played_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_PLAY: begin
                // len beats of TICK_DIV cycles each; cur.len is nonzero here
                if (tick_cnt == TICK_LAST) begin
                    tick_d = '0;
                    if (beat_cnt == cur.len - 1'b1) begin
                        advance = 1'b1;
                    end else begin
                        beat_d = beat_cnt + 1'b1;
                    end
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (step_idx != LAST_STEP) begin
                step_d  = step_idx + 1'b1;
                state_d = ST_LOAD;
            end else if (bus.loop && played) begin
                // an all-silent-length pattern never loops, it finishes
                step_d   = '0;
                played_d = 1'b0;
                state_d  = ST_LOAD;
            end else begin
                state_d = ST_DONE;
            end
        end

        if (bus.stop && state != ST_IDLE) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            step_idx <= '0;
            tick_cnt <= '0;
            beat_cnt <= '0;
            played   <= 1'b0;
            cur      <= '0;
        end else begin
            state    <= state_d;
            step_idx <= step_d;
            tick_cnt <= tick_d;
            beat_cnt <= beat_d;
            played   <= played_d;
            if (load_cur) begin
                cur <= mem_rd;
            end
        end
    end

    // The divider restarts whenever the FSM is outside PLAY, so each step's
    // tone begins low in its first PLAY cycle.
    tone_div #(.DIV_W(DIV_W)) u_tone_div (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_PLAY),
        .en    ((state == ST_PLAY) && !cur.rest),
        .div   (cur.div),
        .tone  (tone_raw)
    );

    assign bus.busy        = (state != ST_IDLE);
    assign bus.step_idx    = step_idx;
    assign bus.step_strobe = (state == ST_LOAD);
    assign bus.done        = (state == ST_DONE);
    assign bus.tone_out    = tone_raw && (state == ST_PLAY) && !cur.rest && (cur.div != '0);

endmodule
